// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/result bundle between the MIPS core (master) and the
// sequential HI/LO multiplier (slave). Clock and reset stay outside as plain ports.
interface mult_seq_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        signmult;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output a, b, signmult, start,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, signmult, start,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: radix-2 shift-add 32x32 -> 64 multiplier for MULT/MULTU.
// Operands are reduced to magnitudes on start, multiplied one bit per clock,
// and the sign is reapplied in a final SGN cycle before the one-cycle done pulse.
// Optional build macro MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero instead of always running 32 iterations.
module mult_seq (
  input  logic      clk,
  input  logic      multrst,
  mult_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, SGN, DONE} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] ub;
  logic [5:0]  count;
  logic        neg;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic [63:0] acc_next;
  logic [31:0] ub_shift;
  logic        run_exit;

  // Unsigned magnitude; 0x80000000 maps to 2^31 because the result is read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    logic signed [31:0] xs;
    xs = x;
    if (sgn && (xs < 0))
      return $unsigned(-xs);
    return x;
  endfunction

  // Two's complement negate of the full 64-bit product.
  function automatic logic [63:0] negate64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  assign acc_next = ub[0] ? (acc + mcand) : acc;
  assign ub_shift = ub >> 1;

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no multiplier bits remain; the 32nd iteration is the hard limit.
  assign run_exit = (ub_shift == 32'd0) || (count == 6'd31);
`else
  // The 32nd iteration (count moving to 32) is always the last.
  assign run_exit = (count == 6'd31);
`endif

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Control FSM and datapath: accept, iterate, apply sign, pulse done.
  always_ff @(posedge clk or posedge multrst) begin
    if (multrst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      ub     <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ub     <= magnitude(bus.b, bus.signmult);
            mcand  <= {32'd0, magnitude(bus.a, bus.signmult)};
            neg    <= bus.signmult & (bus.a[31] ^ bus.b[31]);
            acc    <= '0;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          ub    <= ub_shift;
          count <= count + 6'd1;
          if (run_exit)
            state <= SGN;
        end
        SGN: begin
          {hi_r, lo_r} <= neg ? negate64(acc) : acc;
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
          state        <= DONE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq. Products and latencies come
// from a plain-arithmetic reference; the MULT_EARLY_EXIT_EN macro selects the
// matching latency rule.
module tb_mult_seq;

  logic clk;
  logic multrst;
  int   vectors;
  int   errors;

  mult_seq_if bus ();

  mult_seq dut (
    .clk     (clk),
    .multrst (multrst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: sign- or zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Reference latency in cycles from the start edge to the done cycle.
  function automatic int ref_lat(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int top;
    m = (s && y[31]) ? (32'd0 - y) : y;
    top = 0;
    for (int i = 0; i < 32; i++)
      if (m[i]) top = i;
    return top + 2;
`else
    return 33 + 0 * int'(y[0] & s);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one edge (E0), then scramble the operands to expose late sampling.
  task automatic do_start(input logic [31:0] x, input logic [31:0] y, input logic s);
    bus.a        = x;
    bus.b        = y;
    bus.signmult = s;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.signmult = 1'($urandom);
  endtask

  // Count edges until done is seen; bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 100) begin
      tick();
      lat++;
      if (bus.done) ok = 1'b1;
    end
  endtask

  // One complete multiply with checks on busy, latency and result.
  task automatic run_one(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic s);
    logic [63:0] exp_p;
    int   lat;
    logic ok;
    exp_p = ref_prod(x, y, s);
    do_start(x, y, s);
    vectors++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", name, bus.busy);
    end
    wait_done(lat, ok);
    vectors++;
    if (!ok || lat != ref_lat(y, s)) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d (done_seen=%b)", name, lat, ref_lat(y, s), ok);
    end
    vectors++;
    if ({bus.hi, bus.lo} !== exp_p) begin
      errors++;
      $display("FAIL %s product a=%h b=%h s=%b got %h_%h want %h", name, x, y, s,
               bus.hi, bus.lo, exp_p);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done got %b want 0", name, bus.busy);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got %b want 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    multrst   = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.signmult = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b want all 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    multrst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_one("umax",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_one("smixed",    32'hFFFF_FFFD, 32'd7,         1'b1);
    run_one("smin_sq",   32'h8000_0000, 32'h8000_0000, 1'b1);
    run_one("umin_sq",   32'h8000_0000, 32'h8000_0000, 1'b0);
    run_one("b_one",     32'h1234_5678, 32'd1,         1'b0);
    run_one("b_bit16",   32'h0000_0003, 32'h0001_0000, 1'b0);
    run_one("b_zero",    32'hDEAD_BEEF, 32'd0,         1'b1);
    run_one("sneg_neg",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = y >> (i % 31);
      run_one("random", x, y, 1'(i % 2));
    end
  endtask

  task automatic test_start_busy();
    int   lat;
    int   extra;
    logic ok;
`ifdef MULT_EARLY_EXIT_EN
    extra = 2;
`else
    extra = 10;
`endif
    do_start(32'd5, 32'd6, 1'b0);
    repeat (extra - 1) tick();
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat, ok);
    vectors++;
    if (!ok || (lat + extra) != ref_lat(32'd6, 1'b0)) begin
      errors++;
      $display("FAIL start_busy latency got %0d want %0d", lat + extra, ref_lat(32'd6, 1'b0));
    end
    vectors++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h1E) begin
      errors++;
      $display("FAIL start_busy result got %h_%h want 00000000_0000001e", bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic ok;
    logic [63:0] first;
    logic [31:0] x2, y2;
    x2 = $urandom;
    y2 = $urandom | 32'h8000_0000;
    first = ref_prod(32'h0000_1234, 32'h0000_5678, 1'b0);
    do_start(32'h0000_1234, 32'h0000_5678, 1'b0);
    wait_done(lat, ok);
    // Still inside the done cycle: the new start is taken on the next edge.
    do_start(x2, y2, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.hi, bus.lo} !== first) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b hl=%h_%h want 1 0 %h",
               bus.busy, bus.done, bus.hi, bus.lo, first);
    end
    wait_done(lat, ok);
    vectors++;
    if (!ok || (lat + 1) != ref_lat(y2, 1'b0) + 1) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want %0d", lat + 1, ref_lat(y2, 1'b0) + 1);
    end
    vectors++;
    if ({bus.hi, bus.lo} !== ref_prod(x2, y2, 1'b0)) begin
      errors++;
      $display("FAIL b2b_result got %h_%h want %h", bus.hi, bus.lo, ref_prod(x2, y2, 1'b0));
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int seen;
    run_one("pre_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_start(32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
    repeat (14) tick();
    multrst = 1'b1;
    #1;
    vectors++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got hi=%h lo=%h busy=%b done=%b want all 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    multrst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", seen);
    end
    run_one("post_reset", 32'd2, 32'd3, 1'b0);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_busy();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
